i2s_serializer: RTL

//   Stereo I2S transmit serializer; sits directly downstream of the audio timing generator.

---
 rtl/i2s_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/i2s_serializer.sv
// Stereo I2S transmit serializer: 2-entry frame FIFO feeding a 2*BPS shift register,
// loaded on the frame strobe and shifted MSB-first on each BCLK falling-edge strobe.
module i2s_serializer #(
    parameter int unsigned BITS_PER_SAMPLE = 16,
    parameter int unsigned UNDERRUN_REPEAT = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_i2s_data_load_strobe,
    input  logic                       i_i2s_data_shift_strobe,
    input  logic [BITS_PER_SAMPLE-1:0] i_sample_l,
    input  logic [BITS_PER_SAMPLE-1:0] i_sample_r,
    input  logic                       i_sample_valid,
    output logic                       o_sample_ready,
    input  logic                       i_mute,
    output logic                       o_i2s_data,
    output logic                       o_underrun,
    output logic [15:0]                o_underrun_count
);

    localparam int unsigned FrameW = 2 * BITS_PER_SAMPLE;
    localparam int unsigned CntW   = $clog2(FrameW + 1);

    logic [BITS_PER_SAMPLE-1:0] r_fifo_l [2];
    logic [BITS_PER_SAMPLE-1:0] r_fifo_r [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_count;

    logic [FrameW-1:0]          r_shift_reg;
    logic [FrameW-1:0]          r_last_frame;
    logic [CntW-1:0]            r_bit_count;
    logic                       r_i2s_data;
    logic                       r_underrun;
    logic [15:0]                r_underrun_count;

    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [FrameW-1:0]          w_head_frame;
    logic [FrameW-1:0]          w_shift_d;
    logic [CntW-1:0]            w_bit_count_d;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign o_sample_ready = (r_count != 2'd2);
    assign w_empty        = (r_count == 2'd0);
    assign w_push         = i_sample_valid && o_sample_ready;
    assign w_pop          = i_i2s_data_load_strobe && !w_empty;
    assign w_head_frame   = {r_fifo_l[r_rd_ptr], r_fifo_r[r_rd_ptr]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_l[i] <= '0;
                r_fifo_r[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_l[r_wr_ptr] <= i_sample_l;
                r_fifo_r[r_wr_ptr] <= i_sample_r;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Load has priority over shift; a coincident shift strobe is dropped.
    always_comb begin
        w_shift_d     = r_shift_reg;
        w_bit_count_d = r_bit_count;
        if (i_i2s_data_load_strobe) begin
            w_bit_count_d = '0;
            if (i_mute) begin
                w_shift_d = '0;
            end else if (!w_empty) begin
                w_shift_d = w_head_frame;
            end else if (UNDERRUN_REPEAT != 0) begin
                w_shift_d = r_last_frame;
            end else begin
                w_shift_d = '0;
            end
        end else if (i_i2s_data_shift_strobe) begin
            w_shift_d = {r_shift_reg[FrameW-2:0], 1'b0};
            if (r_bit_count != CntW'(FrameW)) begin
                w_bit_count_d = r_bit_count + CntW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift_reg      <= '0;
            r_last_frame     <= '0;
            r_bit_count      <= '0;
            r_i2s_data       <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= 16'd0;
        end else begin
            r_shift_reg <= w_shift_d;
            r_bit_count <= w_bit_count_d;
            r_i2s_data  <= w_shift_d[FrameW-1];
            r_underrun  <= i_i2s_data_load_strobe && w_empty;
            if (w_pop) begin
                r_last_frame <= w_head_frame;
            end
            if (i_i2s_data_load_strobe && w_empty && (r_underrun_count != 16'hFFFF)) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

    assign o_i2s_data       = r_i2s_data;
    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrun_count;

endmodule
